// File: rtl/dot11_tx_encoder_pkg.sv
// Shared types, constants and helpers for the 802.11a/g DATA-field transmit encoder.
package dot11_tx_encoder_pkg;

    typedef enum logic [2:0] {
        S_TX_IDLE,
        S_TX_SERVICE,
        S_TX_DATA,
        S_TX_TAIL,
        S_TX_PAD,
        S_TX_DONE
    } tx_state_t;

    localparam logic [6:0] G0           = 7'o133;
    localparam logic [6:0] G1           = 7'o171;
    localparam int         SERVICE_BITS = 16;
    localparam int         TAIL_BITS    = 6;

    function automatic logic n_dbps_legal(input logic [7:0] n);
        case (n)
            8'd24, 8'd36, 8'd48, 8'd72, 8'd96, 8'd144, 8'd192, 8'd216: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    // Tap vector runs from the current bit (MSB) to the oldest delay (LSB),
    // so the octal generator polynomials apply directly.
    function automatic logic [1:0] conv_pair(input logic b, input logic [5:0] r);
        logic [6:0] taps;
        taps = {b, r[0], r[1], r[2], r[3], r[4], r[5]};
        return {^(taps & G1), ^(taps & G0)};
    endfunction

endpackage

// File: rtl/dot11_conv_encoder.sv
// K=7 rate-1/2 convolutional encoder; one registered coded pair per input strobe.
module dot11_conv_encoder
    import dot11_tx_encoder_pkg::*;
(
    input  logic       clock,
    input  logic       reset,
    input  logic       enable,
    input  logic       clear,
    input  logic       bit_in,
    input  logic       bit_in_stb,
    output logic [1:0] out,
    output logic       out_stb
);

    logic [5:0] shift_reg;

    always_ff @(posedge clock) begin
        if (reset) begin
            shift_reg <= 6'd0;
            out       <= 2'd0;
            out_stb   <= 1'b0;
        end else if (enable) begin
            if (clear) begin
                shift_reg <= 6'd0;
                out_stb   <= 1'b0;
            end else begin
                out_stb <= bit_in_stb;
                if (bit_in_stb) begin
                    out       <= conv_pair(bit_in, shift_reg);
                    shift_reg <= {shift_reg[4:0], bit_in};
                end
            end
        end
    end

endmodule

// File: rtl/dot11_tx_encoder.sv
// 802.11a/g DATA-field bit encoder: SERVICE + PSDU + tail + pad, scrambled, then K=7 coded.
module dot11_tx_encoder
    import dot11_tx_encoder_pkg::*;
#(
    parameter logic [6:0] DEFAULT_SEED = 7'h5D,
    parameter int         LEN_W        = 12
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             enable,
    input  logic             start,
    input  logic [LEN_W-1:0] len,
    input  logic [7:0]       n_dbps,
    input  logic [6:0]       seed,
    input  logic [7:0]       byte_in,
    input  logic             byte_in_valid,
    output logic             byte_in_ready,
    output logic [1:0]       enc_out,
    output logic             enc_out_valid,
    input  logic             enc_out_ready,
    output logic             busy,
    output logic             done,
    output logic             error,
    output logic [11:0]      sym_count
);

    tx_state_t        state_reg;
    logic [LEN_W-1:0] len_reg;
    logic [LEN_W-1:0] byte_cnt_reg;
    logic [7:0]       n_dbps_reg;
    logic [7:0]       sym_bit_reg;
    logic [6:0]       scr_reg;
    logic [7:0]       byte_reg;
    logic [2:0]       bit_idx_reg;
    logic [4:0]       sec_cnt_reg;
    logic             hold_reg;

    logic adv, in_frame, need_byte, bit_take, raw_bit, fb, scr_bit, start_ok, sym_wrap;
    logic enc_stb;

    // A pair stays valid either because it was just produced or because it is still unaccepted.
    assign enc_out_valid = enc_stb | hold_reg;
    assign adv           = enable && (!enc_out_valid || enc_out_ready);
    assign in_frame      = (state_reg == S_TX_SERVICE) || (state_reg == S_TX_DATA) ||
                           (state_reg == S_TX_TAIL)    || (state_reg == S_TX_PAD);
    assign need_byte     = (state_reg == S_TX_DATA) && (bit_idx_reg == 3'd0);
    assign byte_in_ready = need_byte && adv;
    assign bit_take      = adv && in_frame && (!need_byte || byte_in_valid);
    assign raw_bit       = (state_reg != S_TX_DATA) ? 1'b0 :
                           need_byte ? byte_in[0] : byte_reg[bit_idx_reg];
    assign fb            = scr_reg[6] ^ scr_reg[3];
    assign scr_bit       = (state_reg == S_TX_TAIL) ? 1'b0 : (raw_bit ^ fb);
    assign start_ok      = enable && start && (state_reg == S_TX_IDLE) &&
                           n_dbps_legal(n_dbps) && (len != '0);
    assign sym_wrap      = (sym_bit_reg == n_dbps_reg - 8'd1);

    dot11_conv_encoder u_enc (
        .clock      (clock),
        .reset      (reset),
        .enable     (enable),
        .clear      (start_ok),
        .bit_in     (scr_bit),
        .bit_in_stb (bit_take),
        .out        (enc_out),
        .out_stb    (enc_stb)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            state_reg    <= S_TX_IDLE;
            len_reg      <= '0;
            byte_cnt_reg <= '0;
            n_dbps_reg   <= 8'd0;
            sym_bit_reg  <= 8'd0;
            scr_reg      <= 7'd0;
            byte_reg     <= 8'd0;
            bit_idx_reg  <= 3'd0;
            sec_cnt_reg  <= 5'd0;
            hold_reg     <= 1'b0;
            busy         <= 1'b0;
            done         <= 1'b0;
            error        <= 1'b0;
            sym_count    <= 12'd0;
        end else if (enable) begin
            done     <= 1'b0;
            error    <= 1'b0;
            hold_reg <= enc_out_valid && !enc_out_ready;
            if (bit_take) begin
                scr_reg <= {scr_reg[5:0], fb};
                if (sym_wrap) begin
                    sym_bit_reg <= 8'd0;
                    sym_count   <= sym_count + 12'd1;
                end else begin
                    sym_bit_reg <= sym_bit_reg + 8'd1;
                end
            end
            case (state_reg)
                S_TX_IDLE: begin
                    if (start_ok) begin
                        len_reg     <= len;
                        n_dbps_reg  <= n_dbps;
                        scr_reg     <= (seed == 7'd0) ? DEFAULT_SEED : seed;
                        sym_bit_reg <= 8'd0;
                        sym_count   <= 12'd0;
                        sec_cnt_reg <= 5'd0;
                        busy        <= 1'b1;
                        state_reg   <= S_TX_SERVICE;
                    end else if (start) begin
                        error <= 1'b1;
                    end
                end
                S_TX_SERVICE: begin
                    if (bit_take) begin
                        if (sec_cnt_reg == 5'(SERVICE_BITS - 1)) begin
                            sec_cnt_reg  <= 5'd0;
                            bit_idx_reg  <= 3'd0;
                            byte_cnt_reg <= '0;
                            state_reg    <= S_TX_DATA;
                        end else begin
                            sec_cnt_reg <= sec_cnt_reg + 5'd1;
                        end
                    end
                end
                S_TX_DATA: begin
                    if (bit_take) begin
                        if (need_byte) byte_reg <= byte_in;
                        bit_idx_reg <= bit_idx_reg + 3'd1;
                        if (bit_idx_reg == 3'd7) begin
                            byte_cnt_reg <= byte_cnt_reg + 1'b1;
                            if (byte_cnt_reg == len_reg - 1'b1) state_reg <= S_TX_TAIL;
                        end
                    end
                end
                S_TX_TAIL: begin
                    if (bit_take) begin
                        if (sec_cnt_reg == 5'(TAIL_BITS - 1)) begin
                            sec_cnt_reg <= 5'd0;
                            state_reg   <= sym_wrap ? S_TX_DONE : S_TX_PAD;
                        end else begin
                            sec_cnt_reg <= sec_cnt_reg + 5'd1;
                        end
                    end
                end
                S_TX_PAD: begin
                    if (bit_take && sym_wrap) state_reg <= S_TX_DONE;
                end
                S_TX_DONE: begin
                    if (!enc_out_valid || enc_out_ready) begin
                        done      <= 1'b1;
                        busy      <= 1'b0;
                        state_reg <= S_TX_IDLE;
                    end
                end
                default: state_reg <= S_TX_IDLE;
            endcase
        end
    end

endmodule
